// File: rtl/matrix_multiply_mac_param_if.sv
// Host/control bundle for matrix_multiply_mac_param.
// The master side drives start/host writes; the slave side is the accelerator.
interface matrix_multiply_mac_param_if #(
  parameter int N  = 8,
  parameter int DW = 8
);
  localparam int OW = 2*DW + $clog2(N);
  localparam int AW = $clog2(N*N);

  logic          start;
  logic          acc_en;
  logic          host_we;
  logic [1:0]    host_sel;
  logic [AW-1:0] host_addr;
  logic [OW-1:0] host_wdata;
  logic [OW-1:0] host_rdata;
  logic          busy;
  logic          done;
  logic [15:0]   clock_count;

  modport master (
    output start, acc_en, host_we, host_sel, host_addr, host_wdata,
    input  host_rdata, busy, done, clock_count
  );

  modport slave (
    input  start, acc_en, host_we, host_sel, host_addr, host_wdata,
    output host_rdata, busy, done, clock_count
  );
endinterface

// File: rtl/matrix_multiply_mac_param.sv
// Signed NxN matrix multiply / multiply-accumulate with P parallel MAC lanes,
// banked A/B/C RAMs behind a host port and an exact per-run cycle counter.
module matrix_multiply_mac_param #(
  parameter int N  = 8,
  parameter int P  = 8,
  parameter int DW = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  matrix_multiply_mac_param_if.slave bus
);
  localparam int OW    = 2*DW + $clog2(N);
  localparam int AW    = $clog2(N*N);
  localparam int PW    = 2*DW;
  localparam int G     = N / P;
  localparam int DEPTH = (N*N) / P;
  localparam int BW    = $clog2(DEPTH);
  localparam int KW    = $clog2(N);
  localparam int GW    = (G > 1) ? $clog2(G) : 1;
  localparam int LW    = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  function automatic logic signed [OW-1:0] sext_elem(input logic signed [DW-1:0] v);
    return {{(OW-DW){v[DW-1]}}, v};
  endfunction

  function automatic logic signed [OW-1:0] sext_prod(input logic signed [PW-1:0] v);
    return {{(OW-PW){v[PW-1]}}, v};
  endfunction

  function automatic logic signed [PW-1:0] mul_full(input logic signed [DW-1:0] a,
                                                    input logic signed [DW-1:0] b);
    logic signed [PW-1:0] ae;
    logic signed [PW-1:0] be;
    ae = {{DW{a[DW-1]}}, a};
    be = {{DW{b[DW-1]}}, b};
    return ae * be;
  endfunction

  function automatic logic signed [OW-1:0] wrap_add(input logic signed [OW-1:0] a,
                                                    input logic signed [OW-1:0] b);
    return a + b;
  endfunction

  logic signed [DW-1:0] r_mem_a [P][DEPTH];
  logic signed [DW-1:0] r_mem_b [N*N];
  logic signed [OW-1:0] r_mem_c [P][DEPTH];

  state_t        r_state, w_next;
  logic          w_busy, w_done;
  logic [KW-1:0] r_c, r_k;
  logic [GW-1:0] r_g;
  logic [1:0]    r_drain;
  logic          r_acc_en;
  logic [15:0]   r_count;
  logic [OW-1:0] r_rdata;

  logic          w_last_issue, w_host_wr;
  logic [LW-1:0] w_hbank;
  logic [BW-1:0] w_hidx, w_a_idx, w_c_idx;
  logic [AW-1:0] w_b_addr;

  logic                 r_vld_p1, r_vld_p2, r_vld_p3;
  logic [KW-1:0]        r_k_p1, r_k_p2;
  logic                 r_last_p3;
  logic [BW-1:0]        r_widx_p1, r_widx_p2, r_widx_p3;
  logic signed [DW-1:0] r_a_p1 [P];
  logic signed [DW-1:0] r_b_p1;
  logic signed [OW-1:0] r_cold_p1 [P];
  logic signed [PW-1:0] r_prod_p2 [P];
  logic signed [OW-1:0] r_cold_p2 [P];
  logic signed [OW-1:0] r_acc_p3 [P];
  logic signed [OW-1:0] r_cold_p3 [P];
  logic signed [OW-1:0] w_wb [P];

  // Element r + N*c lives in bank r mod P at index (r + N*c) / P.
  assign w_hbank   = LW'(bus.host_addr % P);
  assign w_hidx    = BW'(bus.host_addr / P);
  assign w_host_wr = bus.host_we && !w_busy;

  assign w_a_idx      = BW'(int'(r_g) + G*int'(r_k));
  assign w_c_idx      = BW'(int'(r_g) + G*int'(r_c));
  assign w_b_addr     = AW'(int'(r_k) + N*int'(r_c));
  assign w_last_issue = (r_k == KW'(N-1)) && (r_g == GW'(G-1)) && (r_c == KW'(N-1));

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = S_RUN;
      end
      S_RUN:   if (w_last_issue) w_next = S_DRAIN;
      S_DRAIN: if (r_drain == 2'd2) w_next = S_DONE;
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Loop order is c outermost, then row group g, then k innermost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_c      <= '0;
      r_g      <= '0;
      r_k      <= '0;
      r_drain  <= '0;
      r_acc_en <= 1'b0;
      r_count  <= '0;
    end else begin
      r_drain <= (r_state == S_DRAIN) ? r_drain + 2'd1 : 2'd0;
      if (r_state != S_IDLE) r_count <= r_count + 16'd1;
      if (r_state == S_IDLE && bus.start) begin
        r_acc_en <= bus.acc_en;
        r_count  <= '0;
        r_c      <= '0;
        r_g      <= '0;
        r_k      <= '0;
      end else if (r_state == S_RUN) begin
        if (r_k == KW'(N-1)) begin
          r_k <= '0;
          if (r_g == GW'(G-1)) begin
            r_g <= '0;
            r_c <= r_c + 1'b1;
          end else begin
            r_g <= r_g + 1'b1;
          end
        end else begin
          r_k <= r_k + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0;
    end else begin
      r_vld_p1 <= (r_state == S_RUN);
      r_vld_p2 <= r_vld_p1;
      r_vld_p3 <= r_vld_p2;
    end
  end

  // Stage 1: registered RAM reads (A per lane, broadcast B, old C for accumulate)
  always_ff @(posedge clk) begin
    r_b_p1    <= r_mem_b[w_b_addr];
    r_k_p1    <= r_k;
    r_widx_p1 <= w_c_idx;
    for (int l = 0; l < P; l++) begin
      r_a_p1[l]    <= r_mem_a[l][w_a_idx];
      r_cold_p1[l] <= r_mem_c[l][w_c_idx];
    end
  end

  // Stage 2: product register
  always_ff @(posedge clk) begin
    r_k_p2    <= r_k_p1;
    r_widx_p2 <= r_widx_p1;
    for (int l = 0; l < P; l++) begin
      r_prod_p2[l] <= mul_full(r_a_p1[l], r_b_p1);
      r_cold_p2[l] <= r_cold_p1[l];
    end
  end

  // Stage 3: accumulator, reloaded at k = 0
  always_ff @(posedge clk) begin
    r_last_p3 <= (r_k_p2 == KW'(N-1));
    r_widx_p3 <= r_widx_p2;
    for (int l = 0; l < P; l++) begin
      r_cold_p3[l] <= r_cold_p2[l];
      if (r_vld_p2) begin
        if (r_k_p2 == '0) r_acc_p3[l] <= sext_prod(r_prod_p2[l]);
        else              r_acc_p3[l] <= r_acc_p3[l] + sext_prod(r_prod_p2[l]);
      end
    end
  end

  // Stage 4: write-back of all lanes, optionally adding old C modulo 2^OW
  always_comb begin
    for (int l = 0; l < P; l++)
      w_wb[l] = r_acc_en ? wrap_add(r_acc_p3[l], r_cold_p3[l]) : r_acc_p3[l];
  end

  always_ff @(posedge clk) begin
    if (w_host_wr) begin
      case (bus.host_sel)
        2'd0:    r_mem_a[w_hbank][w_hidx] <= bus.host_wdata[DW-1:0];
        2'd1:    r_mem_b[bus.host_addr]   <= bus.host_wdata[DW-1:0];
        2'd2:    r_mem_c[w_hbank][w_hidx] <= bus.host_wdata;
        default: ;
      endcase
    end
    for (int l = 0; l < P; l++)
      if (r_vld_p3 && r_last_p3) r_mem_c[l][r_widx_p3] <= w_wb[l];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (!w_busy) begin
      case (bus.host_sel)
        2'd0:    r_rdata <= sext_elem(r_mem_a[w_hbank][w_hidx]);
        2'd1:    r_rdata <= sext_elem(r_mem_b[bus.host_addr]);
        2'd2:    r_rdata <= r_mem_c[w_hbank][w_hidx];
        default: r_rdata <= '0;
      endcase
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.clock_count = r_count;
  assign bus.host_rdata  = r_rdata;
endmodule
